// File: rtl/mist1032sa_uart_rx_controller.sv
//==============================================================================
// Module      : mist1032sa_uart_rx_controller
// Description : UART receiver controller. Owns the receiver baud count and its
//               reset (held low for a fixed time after reset or reconfig),
//               buffers received bytes in a FWFT FIFO with a valid/request
//               read port, and reports fill level, overrun and interrupts.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mist1032sa_uart_rx_controller #(
   parameter int unsigned FIFO_DEPTH_N   = 4,
   parameter logic [19:0] DEFAULT_BAUD   = 20'd108,
   parameter logic [7:0]  RESET_HOLD     = 8'd16,
   parameter logic [19:0] TIMEOUT_CYCLES = 20'd4000
) (
   input  logic                    iCLOCK,
   input  logic                    iRESET_SYNC,
   input  logic                    iBAUD_WR,
   input  logic [19:0]             iBAUD_DATA,
   input  logic                    iRX_ENA,
   input  logic [FIFO_DEPTH_N:0]   iIRQ_LEVEL,
   input  logic                    iOVERRUN_CLR,
   output logic                    oUART_RESET_N,
   output logic [19:0]             oEXTBAUD_COUNT,
   input  logic                    iRX_VALID,
   input  logic [7:0]              iRX_DATA,
   output logic                    oRD_VALID,
   output logic [7:0]              oRD_DATA,
   input  logic                    iRD_REQ,
   output logic [FIFO_DEPTH_N:0]   oCOUNT,
   output logic                    oOVERRUN,
   output logic                    oIRQ,
   output logic                    oBUSY
);

   localparam int unsigned           c_DEPTH      = 1 << FIFO_DEPTH_N;
   localparam logic [FIFO_DEPTH_N:0] c_FULL_COUNT = {1'b1, {FIFO_DEPTH_N{1'b0}}};
   localparam logic [FIFO_DEPTH_N:0] c_CNT_ONE    = {{FIFO_DEPTH_N{1'b0}}, 1'b1};
   localparam logic [FIFO_DEPTH_N:0] c_CNT_ZERO   = '0;
   localparam logic [FIFO_DEPTH_N-1:0] c_PTR_ONE  = {{(FIFO_DEPTH_N-1){1'b0}}, 1'b1};
   localparam logic [19:0]           c_MIN_BAUD   = 20'd4;

   typedef enum logic [0:0] {
      ST_HOLD = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   // Receiver control state
   state_t      state_q;
   logic [7:0]  hold_cnt_q;
   logic [19:0] baud_q;
   logic [19:0] baud_d;
   logic        uart_rst_n_q;
   logic        busy_q;

   // FIFO state
   logic [7:0]              mem_q [c_DEPTH];
   logic [FIFO_DEPTH_N-1:0] wr_ptr_q;
   logic [FIFO_DEPTH_N-1:0] rd_ptr_q;
   logic [FIFO_DEPTH_N:0]   count_q;
   logic [FIFO_DEPTH_N:0]   count_d;
   logic                    rd_valid_q;
   logic                    overrun_q;

   // Idle timeout state
   logic [19:0] timer_q;
   logic        timeout_q;

   logic w_push;
   logic w_pop;
   logic w_full;
   logic w_wr_en;
   logic w_ovr_set;
   logic w_level_irq;

   // Baud values below the receiver minimum are clamped up to it
   always_comb begin
      baud_d = (iBAUD_DATA < c_MIN_BAUD) ? c_MIN_BAUD : iBAUD_DATA;
   end

   // Hold/run sequencer with registered receiver reset, busy and baud outputs
   always_ff @(posedge iCLOCK) begin
      if (iRESET_SYNC) begin
         state_q      <= ST_HOLD;
         hold_cnt_q   <= 8'd0;
         baud_q       <= DEFAULT_BAUD;
         uart_rst_n_q <= 1'b0;
         busy_q       <= 1'b1;
      end else if (iBAUD_WR) begin
         // A new baud count always restarts the receiver from a clean reset
         state_q      <= ST_HOLD;
         hold_cnt_q   <= 8'd0;
         baud_q       <= baud_d;
         uart_rst_n_q <= 1'b0;
         busy_q       <= 1'b1;
      end else begin
         case (state_q)
            ST_HOLD: begin
               if (hold_cnt_q == (RESET_HOLD - 8'd1)) begin
                  state_q      <= ST_RUN;
                  uart_rst_n_q <= 1'b1;
                  busy_q       <= 1'b0;
               end else begin
                  hold_cnt_q <= hold_cnt_q + 8'd1;
               end
            end
            ST_RUN: begin
               uart_rst_n_q <= 1'b1;
               busy_q       <= 1'b0;
            end
            default: begin
               state_q      <= ST_HOLD;
               hold_cnt_q   <= 8'd0;
               uart_rst_n_q <= 1'b0;
               busy_q       <= 1'b1;
            end
         endcase
      end
   end

   // Push/pop qualification; a full FIFO still accepts a push paired with a pop
   always_comb begin
      w_push    = iRX_VALID & iRX_ENA & (state_q == ST_RUN);
      w_pop     = iRD_REQ & rd_valid_q;
      w_full    = (count_q == c_FULL_COUNT);
      w_wr_en   = w_push & (~w_full | w_pop);
      w_ovr_set = w_push & w_full & ~w_pop;
   end

   // Next fill level
   always_comb begin
      count_d = count_q;
      case ({w_wr_en, w_pop})
         2'b10:   count_d = count_q + c_CNT_ONE;
         2'b01:   count_d = count_q - c_CNT_ONE;
         default: count_d = count_q;
      endcase
   end

   // Byte storage; contents need no reset since validity is tracked by count
   always_ff @(posedge iCLOCK) begin
      if (w_wr_en && !iRESET_SYNC) begin
         mem_q[wr_ptr_q] <= iRX_DATA;
      end
   end

   // FIFO pointers, fill level, valid flag and sticky overrun
   always_ff @(posedge iCLOCK) begin
      if (iRESET_SYNC) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         rd_valid_q <= 1'b0;
         overrun_q  <= 1'b0;
      end else begin
         if (w_wr_en) begin
            wr_ptr_q <= wr_ptr_q + c_PTR_ONE;
         end
         if (w_pop) begin
            rd_ptr_q <= rd_ptr_q + c_PTR_ONE;
         end
         count_q    <= count_d;
         rd_valid_q <= (count_d != c_CNT_ZERO);
         // Setting wins over a simultaneous clear so no drop goes unreported
         if (w_ovr_set) begin
            overrun_q <= 1'b1;
         end else if (iOVERRUN_CLR) begin
            overrun_q <= 1'b0;
         end
      end
   end

   // Idle timer: runs only while data sits untouched, saturates at timeout
   always_ff @(posedge iCLOCK) begin
      if (iRESET_SYNC) begin
         timer_q   <= 20'd0;
         timeout_q <= 1'b0;
      end else if (w_push || w_pop || (count_q == c_CNT_ZERO)) begin
         timer_q   <= 20'd0;
         timeout_q <= 1'b0;
      end else if (timer_q == (TIMEOUT_CYCLES - 20'd1)) begin
         timeout_q <= 1'b1;
      end else begin
         timer_q <= timer_q + 20'd1;
      end
   end

   // Interrupt combines level threshold, idle timeout and overrun
   always_comb begin
      w_level_irq = (iIRQ_LEVEL != c_CNT_ZERO) && (count_q >= iIRQ_LEVEL);
      oIRQ        = w_level_irq | timeout_q | overrun_q;
   end

   assign oUART_RESET_N  = uart_rst_n_q;
   assign oBUSY          = busy_q;
   assign oEXTBAUD_COUNT = baud_q;
   assign oRD_VALID      = rd_valid_q;
   assign oRD_DATA       = rd_valid_q ? mem_q[rd_ptr_q] : 8'h00;
   assign oCOUNT         = count_q;
   assign oOVERRUN       = overrun_q;

endmodule

`default_nettype wire

// File: tb/tb_mist1032sa_uart_rx_controller.sv
//==============================================================================
// Module      : tb_mist1032sa_uart_rx_controller
// Description : Scoreboard bench for the UART receive controller. Directed
//               stimulus pushes expected bytes into a queue; a monitor pops
//               and compares whenever a read is performed.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mist1032sa_uart_rx_controller;

   logic        clk;
   logic        rst;
   logic        baud_wr;
   logic [19:0] baud_data;
   logic        rx_ena;
   logic [4:0]  irq_level;
   logic        ovr_clr;
   logic        uart_rst_n;
   logic [19:0] ext_baud;
   logic        rx_valid;
   logic [7:0]  rx_data;
   logic        rd_valid;
   logic [7:0]  rd_data;
   logic        rd_req;
   logic [4:0]  count;
   logic        overrun;
   logic        irq;
   logic        busy;

   int n_tests = 0;
   int n_fail  = 0;
   logic [7:0] exp_q [$];
   logic [7:0] mon_exp;

   mist1032sa_uart_rx_controller #(
      .FIFO_DEPTH_N   (4),
      .DEFAULT_BAUD   (20'd108),
      .RESET_HOLD     (8'd16),
      .TIMEOUT_CYCLES (20'd100)
   ) dut (
      .iCLOCK         (clk),
      .iRESET_SYNC    (rst),
      .iBAUD_WR       (baud_wr),
      .iBAUD_DATA     (baud_data),
      .iRX_ENA        (rx_ena),
      .iIRQ_LEVEL     (irq_level),
      .iOVERRUN_CLR   (ovr_clr),
      .oUART_RESET_N  (uart_rst_n),
      .oEXTBAUD_COUNT (ext_baud),
      .iRX_VALID      (rx_valid),
      .iRX_DATA       (rx_data),
      .oRD_VALID      (rd_valid),
      .oRD_DATA       (rd_data),
      .iRD_REQ        (rd_req),
      .oCOUNT         (count),
      .oOVERRUN       (overrun),
      .oIRQ           (irq),
      .oBUSY          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: every performed read must present the oldest expected byte
   always @(negedge clk) begin
      if (!rst && rd_req && rd_valid) begin
         n_tests++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL rd_data: got %02h, expected nothing (queue empty)", rd_data);
         end else begin
            mon_exp = exp_q.pop_front();
            if (rd_data !== mon_exp) begin
               n_fail++;
               $display("FAIL rd_data: got %02h, expected %02h", rd_data, mon_exp);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic push_byte(input logic [7:0] b, input bit accept);
      rx_valid = 1'b1;
      rx_data  = b;
      if (accept) exp_q.push_back(b);
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic pop_byte();
      rd_req = 1'b1;
      tick();
      rd_req = 1'b0;
   endtask

   // Counts samples with the receiver held in reset, starting at the current one
   task automatic count_hold(output int n);
      n = 0;
      while (!uart_rst_n && n < 40) begin
         n++;
         tick();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b1; baud_wr = 1'b0; baud_data = 20'd0; rx_ena = 1'b0;
      irq_level = 5'd0; ovr_clr = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      rd_req = 1'b0;

      // Reset state
      tick(); tick();
      check("rst_uart_rst_n", {31'd0, uart_rst_n}, 32'd0);
      check("rst_busy",       {31'd0, busy},       32'd1);
      check("rst_baud",       {12'd0, ext_baud},   32'd108);
      check("rst_rd_valid",   {31'd0, rd_valid},   32'd0);
      check("rst_rd_data",    {24'd0, rd_data},    32'd0);
      check("rst_count",      {27'd0, count},      32'd0);
      check("rst_overrun",    {31'd0, overrun},    32'd0);
      check("rst_irq",        {31'd0, irq},        32'd0);

      rst = 1'b0;
      count_hold(n);
      check("hold_after_reset", n, 32'd16);
      check("run_busy",  {31'd0, busy},     32'd0);
      check("run_baud",  {12'd0, ext_baud}, 32'd108);
      check("run_count", {27'd0, count},    32'd0);
      check("run_irq",   {31'd0, irq},      32'd0);

      // Capture disabled: byte discarded
      push_byte(8'h12, 1'b0);
      check("ena0_count",   {27'd0, count},   32'd0);
      check("ena0_overrun", {31'd0, overrun}, 32'd0);

      // Basic push/pop ordering
      rx_ena = 1'b1;
      push_byte(8'hA5, 1'b1);
      check("push1_valid", {31'd0, rd_valid}, 32'd1);
      check("push1_count", {27'd0, count},    32'd1);
      push_byte(8'h3C, 1'b1);
      check("push2_count", {27'd0, count},    32'd2);
      check("push2_head",  {24'd0, rd_data},  32'hA5);
      pop_byte();
      check("pop1_count",  {27'd0, count},    32'd1);
      check("pop1_head",   {24'd0, rd_data},  32'h3C);
      pop_byte();
      check("pop2_count",  {27'd0, count},    32'd0);
      check("pop2_valid",  {31'd0, rd_valid}, 32'd0);
      check("pop2_data",   {24'd0, rd_data},  32'h00);

      // Pop on empty is ignored
      pop_byte();
      check("empty_pop_count", {27'd0, count}, 32'd0);

      // Fill to 16, then overflow
      for (int i = 0; i < 16; i++) push_byte(8'h10 + 8'(i), 1'b1);
      check("full_count",   {27'd0, count},   32'd16);
      check("full_overrun", {31'd0, overrun}, 32'd0);
      push_byte(8'hEE, 1'b0);
      check("ovf_count",    {27'd0, count},   32'd16);
      check("ovf_overrun",  {31'd0, overrun}, 32'd1);
      check("ovf_irq",      {31'd0, irq},     32'd1);
      ovr_clr = 1'b1;
      tick();
      ovr_clr = 1'b0;
      check("ovr_clr", {31'd0, overrun}, 32'd0);

      // Set wins over a simultaneous clear
      ovr_clr = 1'b1;
      push_byte(8'hED, 1'b0);
      ovr_clr = 1'b0;
      check("ovr_set_wins", {31'd0, overrun}, 32'd1);
      ovr_clr = 1'b1;
      tick();
      ovr_clr = 1'b0;
      check("ovr_clr2", {31'd0, overrun}, 32'd0);

      // Full FIFO: push and pop together
      rx_valid = 1'b1; rx_data = 8'h77; rd_req = 1'b1;
      exp_q.push_back(8'h77);
      tick();
      rx_valid = 1'b0; rd_req = 1'b0;
      check("fullpp_count",   {27'd0, count},   32'd16);
      check("fullpp_overrun", {31'd0, overrun}, 32'd0);
      check("fullpp_head",    {24'd0, rd_data}, 32'h11);
      for (int i = 0; i < 16; i++) pop_byte();
      check("drain_count", {27'd0, count},    32'd0);
      check("drain_valid", {31'd0, rd_valid}, 32'd0);

      // Level interrupt
      irq_level = 5'd4;
      for (int i = 0; i < 3; i++) push_byte(8'h41 + 8'(i), 1'b1);
      check("lvl3_irq", {31'd0, irq}, 32'd0);
      push_byte(8'h44, 1'b1);
      check("lvl4_irq", {31'd0, irq}, 32'd1);

      // Idle timeout with one byte left
      irq_level = 5'd0;
      for (int i = 0; i < 3; i++) pop_byte();
      check("to_count",     {27'd0, count}, 32'd1);
      check("to_irq_start", {31'd0, irq},   32'd0);
      n = 0;
      while (!irq && n < 200) begin
         n++;
         tick();
      end
      check("timeout_delay", n, 32'd100);
      pop_byte();
      check("timeout_clear_irq", {31'd0, irq},   32'd0);
      check("timeout_clear_cnt", {27'd0, count}, 32'd0);

      // Baud write in run: clamp, hold, discard during hold, FIFO kept
      push_byte(8'h5A, 1'b1);
      baud_wr = 1'b1; baud_data = 20'd2;
      tick();
      baud_wr = 1'b0;
      check("bw_baud", {12'd0, ext_baud}, 32'd4);
      check("bw_busy", {31'd0, busy},     32'd1);
      n = 0;
      while (busy && n < 40) begin
         n++;
         rx_valid = (n == 3);
         rx_data  = 8'h99;
         tick();
      end
      rx_valid = 1'b0;
      check("bw_hold_cycles", n, 32'd16);
      check("bw_count",   {27'd0, count},    32'd1);
      check("bw_head",    {24'd0, rd_data},  32'h5A);
      check("bw_overrun", {31'd0, overrun},  32'd0);
      check("bw_rst_n",   {31'd0, uart_rst_n}, 32'd1);
      pop_byte();

      // Reset mid-operation empties FIFO and restores default baud
      push_byte(8'hC1, 1'b0);
      push_byte(8'hC2, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("mid_rst_count", {27'd0, count},      32'd0);
      check("mid_rst_valid", {31'd0, rd_valid},   32'd0);
      check("mid_rst_baud",  {12'd0, ext_baud},   32'd108);
      check("mid_rst_rst_n", {31'd0, uart_rst_n}, 32'd0);
      count_hold(n);
      check("mid_rst_hold", n, 32'd16);

      check("queue_empty", exp_q.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/mist1032sa_uart_rx_controller.md
# mist1032sa_uart_rx_controller

Controller and buffer for the UART receiver datapath. It owns the receiver's baud count and drives the receiver's reset so it can restart cleanly on reconfiguration. It captures received bytes into a first-word-fall-through FIFO and presents them to the bus side with a valid/request handshake. It also reports fill level, overrun and an interrupt (level or idle-timeout).

## Interface
Parameters:
- FIFO_DEPTH_N, 4 — FIFO depth is 2^FIFO_DEPTH_N entries (16).
- DEFAULT_BAUD, 20'd108 — baud count loaded at reset, in the receiver's format: (Clock/Baudrate)/4-1, must be >= 4.
- RESET_HOLD, 8'd16 — cycles the receiver is held in reset. Must be >= 1.
- TIMEOUT_CYCLES, 20'd4000 — idle cycles before the timeout interrupt.

Ports:
- iCLOCK  in  1  system clock; the receiver runs on the same clock.
- iRESET_SYNC  in  1  synchronous, active-high reset.
- iBAUD_WR  in  1  write strobe for a new baud count.
- iBAUD_DATA  in  20  new baud count; values < 4 are clamped to 4.
- iRX_ENA  in  1  capture enable.
- iIRQ_LEVEL  in  FIFO_DEPTH_N+1  fill-level interrupt threshold; 0 disables the level interrupt.
- iOVERRUN_CLR  in  1  clears oOVERRUN.
- oUART_RESET_N  out  1  active-low reset to the receiver.
- oEXTBAUD_COUNT  out  20  baud count to the receiver.
- iRX_VALID  in  1  one-cycle byte strobe from the receiver.
- iRX_DATA  in  8  received byte.
- oRD_VALID  out  1  FIFO not empty; oRD_DATA holds the head byte.
- oRD_DATA  out  8  head byte; 8'h00 when empty.
- iRD_REQ  in  1  pop the head byte; honoured only when oRD_VALID=1.
- oCOUNT  out  FIFO_DEPTH_N+1  number of bytes in the FIFO.
- oOVERRUN  out  1  sticky flag: a byte was dropped because the FIFO was full.
- oIRQ  out  1  interrupt.
- oBUSY  out  1  receiver reconfiguration in progress.

## Operation
- States:
  - ST_HOLD: oUART_RESET_N=0, oBUSY=1, hold counter running.
  - ST_RUN: oUART_RESET_N=1, oBUSY=0.
- Reset enters ST_HOLD with hold counter=0 and oEXTBAUD_COUNT=DEFAULT_BAUD.
- ST_HOLD -> ST_RUN when the hold counter reaches RESET_HOLD-1.
- iBAUD_WR in either state:
  - latches the clamped iBAUD_DATA into oEXTBAUD_COUNT;
  - enters or re-enters ST_HOLD and restarts the hold counter at 0.
  - The FIFO is not flushed.
- Capture: a byte is pushed when iRX_VALID & iRX_ENA & ST_RUN. iRX_VALID in ST_HOLD or with iRX_ENA=0 is discarded and does not set overrun.
- Full FIFO:
  - push without a pop: the byte is dropped and oOVERRUN is set;
  - push together with a pop: both take effect, oCOUNT is unchanged, no overrun.
- Empty FIFO: iRD_REQ is ignored and oCOUNT stays 0.
- Pointers are FIFO_DEPTH_N bits and wrap modulo depth. oCOUNT is 0..2^FIFO_DEPTH_N.
- Overrun: if set and iOVERRUN_CLR occur in the same cycle, set wins.
- Idle timer:
  - counts iCLOCK cycles while oCOUNT != 0 with no push and no pop;
  - resets to 0 on any push, any pop, or when empty.
  - When it reaches TIMEOUT_CYCLES-1 the timeout flag is set and the timer saturates.
  - The flag clears on the next push, on a pop, or when the FIFO is empty.
- oIRQ = (iIRQ_LEVEL != 0 && oCOUNT >= iIRQ_LEVEL) | timeout flag | oOVERRUN.

## Timing
- All outputs are registered, except oRD_DATA (FIFO head, combinational from the read pointer) and oIRQ (combinational from the registered terms above).
- Reset values:
  - oUART_RESET_N=0, oEXTBAUD_COUNT=DEFAULT_BAUD, oBUSY=1;
  - oRD_VALID=0, oRD_DATA=8'h00, oCOUNT=0, oOVERRUN=0, oIRQ=0.
  - The FIFO is empty; the timer and timeout flag are 0.
- After iRESET_SYNC falls, oUART_RESET_N stays low for exactly RESET_HOLD cycles, then rises and oBUSY falls in the same cycle.
- After iBAUD_WR in cycle T:
  - oEXTBAUD_COUNT takes the new value at T+1;
  - oUART_RESET_N is low for cycles T+1 .. T+RESET_HOLD.
- Push in cycle T: oRD_VALID=1 and oCOUNT incremented at T+1. A byte is never visible in the cycle it is pushed.
- Pop (iRD_REQ & oRD_VALID) in cycle T: the next byte (or empty) is visible at T+1.
- iRESET_SYNC has priority over every other input. Reset mid-operation empties the FIFO and restores DEFAULT_BAUD.

## Test plan
- Reset for 2 cycles, then release → oUART_RESET_N low for 16 cycles, oEXTBAUD_COUNT=108; after release oBUSY=0 and all other outputs at their reset values.
- Push 0xA5, 0x3C, then pop twice → oRD_DATA reads 0xA5 then 0x3C, oCOUNT goes 2→1→0, oRD_VALID=0 at the end, oRD_DATA=0x00.
- Push 17 bytes with no pops → oCOUNT=16, the 17th byte is dropped, oOVERRUN=1, oIRQ=1. Then pulse iOVERRUN_CLR → oOVERRUN=0.
- FIFO full, push and pop in the same cycle → oCOUNT stays 16, oOVERRUN stays 0, head advances; the FIFO then holds the second-pushed through the 17th byte in order (the last pushed byte is at the tail).
- iIRQ_LEVEL=4 → oIRQ=0 after 3 pushes, 1 after the 4th. Then 1 byte left with TIMEOUT_CYCLES=100 and iIRQ_LEVEL=0 → oIRQ rises 100 cycles after the last push/pop and falls on the pop.
- iBAUD_WR with data 2 during ST_RUN, plus iRX_VALID during the hold → oEXTBAUD_COUNT=4, oBUSY=1 for 16 cycles, the byte is discarded, oOVERRUN=0.
